icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache for the IF->ID boundary.
- Registers the fetch PC from the predictor on each pipeline advance and returns the instruction one cycle later for the decoder.
- On a miss it drops `valid`, which stalls the whole pipeline. It then refills the line word-by-word over a simple req/ack memory port.
- Supports whole-cache invalidate for FENCE.I.

---
 rtl/icache_dm.sv | 127 ++++++++++++
 tb/tb_icache_dm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache sitting on the IF->ID boundary.
// The fetch PC is latched on each pipeline advance and the instruction is
// looked up combinationally from the latched PC. A miss drops valid and
// refills the line word 0 upward over a req/ack memory port.
module icache_dm #(
  parameter int          LINES    = 16,
  parameter int          WORDS    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeline_en,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        valid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int          WB  = $clog2(WORDS);
  localparam int          OB  = WB + 2;
  localparam int          IB  = $clog2(LINES);
  localparam int          TW  = 32 - OB - IB;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FILL, DONE} stateT;

  stateT            r_state;
  stateT            w_nextState;
  logic [31:0]      r_pcQ;
  logic [31:0]      r_data [LINES*WORDS];
  logic [TW-1:0]    r_tag  [LINES];
  logic [LINES-1:0] r_lineValid;
  logic [TW-1:0]    r_missTag;
  logic [IB-1:0]    r_missIdx;
  logic [WB-1:0]    r_cnt;
  logic             r_flushPend;

  logic [WB-1:0]    w_word;
  logic [IB-1:0]    w_idx;
  logic [TW-1:0]    w_tag;
  logic             w_hit;
  logic             w_lastAck;
  logic             w_unusedPcBits;

  assign w_word         = r_pcQ[OB-1:2];
  assign w_idx          = r_pcQ[OB+IB-1:OB];
  assign w_tag          = r_pcQ[31:OB+IB];
  assign w_unusedPcBits = ^r_pcQ[1:0];
  assign w_hit          = r_lineValid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_lastAck      = (r_state == FILL) && mem_ack && (r_cnt == WB'(WORDS - 1));

  // Fetch PC latch: follows the predictor whenever the pipeline advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pcQ <= RESET_PC;
    else if (pipeline_en) r_pcQ <= pc;
  end

  // Refill FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_nextState;
  end

  // Next-state and output decode; memory port is idle outside FILL.
  always_comb begin
    w_nextState = r_state;
    valid       = 1'b0;
    inst        = NOP;
    mem_req     = 1'b0;
    mem_addr    = '0;
    if (w_hit) inst = r_data[{w_idx, w_word}];
    case (r_state)
      IDLE: begin
        valid = w_hit;
        if (!w_hit) w_nextState = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_missTag, r_missIdx, r_cnt, 2'b00};
        if (w_lastAck) w_nextState = DONE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Miss bookkeeping: capture the missing line and step the word counter on each ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_missTag <= '0;
      r_missIdx <= '0;
      r_cnt     <= '0;
    end else if ((r_state == IDLE) && !w_hit) begin
      r_missTag <= w_tag;
      r_missIdx <= w_idx;
      r_cnt     <= '0;
    end else if ((r_state == FILL) && mem_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A flush arriving mid-refill is remembered so the new line is dropped afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_flushPend <= 1'b0;
    else if (r_state == FILL && flush) r_flushPend <= 1'b1;
    else if (r_state != FILL) r_flushPend <= 1'b0;
  end

  // Line-valid bits: cleared by flush (immediately in IDLE, after DONE otherwise), set on the last refill word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_lineValid <= '0;
    else if ((r_state == IDLE) && flush) r_lineValid <= '0;
    else if ((r_state == DONE) && (r_flushPend || flush)) r_lineValid <= '0;
    else if (w_lastAck) r_lineValid[r_missIdx] <= 1'b1;
  end

  // Data and tag storage, written only by the refill; deliberately left unreset.
  always_ff @(posedge clk) begin
    if ((r_state == FILL) && mem_ack) r_data[{r_missIdx, r_cnt}] <= mem_rdata;
    if (w_lastAck) r_tag[r_missIdx] <= r_missTag;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed testbench for icache_dm: cold fill, sequential hits, conflict
// eviction, delayed acks, flush in IDLE and mid-fill, reset mid-refill.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipeline_en = 1'b0;
  logic [31:0] pc = 32'h8000_0000;
  logic        flush = 1'b0;
  logic [31:0] inst;
  logic        valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int checkCount = 0;
  int errorCount = 0;

  icache_dm dut (
    .clk(clk), .rst(rst), .pipeline_en(pipeline_en), .pc(pc), .flush(flush),
    .inst(inst), .valid(valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Backing memory contents as seen by the refill port.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h8000_0000: return 32'h0000_0011;
      32'h8000_0004: return 32'h0000_0022;
      32'h8000_0008: return 32'h0000_0033;
      32'h8000_000C: return 32'h0000_0044;
      default:       return {addr[15:0], 16'hBEEF};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] addr, input logic fl);
    pipeline_en = en;
    pc          = addr;
    flush       = fl;
  endtask

  // Wait (bounded) for a request, check it, hold it for 'gap' cycles, then ack it.
  task automatic serveWord(input logic [31:0] addr, input int gap);
    int waitCycles = 0;
    while (mem_req !== 1'b1 && waitCycles < 20) begin
      stepCycle();
      waitCycles++;
    end
    if (mem_req !== 1'b1) begin
      checkOutput("reqTimeout", 32'(mem_req), 32'h1);
      return;
    end
    checkOutput("memAddr", mem_addr, addr);
    checkOutput("missValid", 32'(valid), 32'h0);
    for (int g = 0; g < gap; g++) begin
      stepCycle();
      checkOutput("gapReq", 32'(mem_req), 32'h1);
      checkOutput("gapAddr", mem_addr, addr);
      checkOutput("gapValid", 32'(valid), 32'h0);
    end
    mem_ack   = 1'b1;
    mem_rdata = memWord(addr);
    stepCycle();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  // Full line refill followed by the DONE bubble and the first hit on word 0.
  task automatic serveFill(input logic [31:0] base, input int gap);
    for (int w = 0; w < 4; w++) serveWord(base + 32'(4 * w), gap);
    checkOutput("doneValid", 32'(valid), 32'h0);
    checkOutput("doneReq", 32'(mem_req), 32'h0);
    stepCycle();
    checkOutput("hitValid", 32'(valid), 32'h1);
    checkOutput("hitInst", inst, memWord(base));
    checkOutput("hitReq", 32'(mem_req), 32'h0);
  endtask

  // Directed scenario sequence.
  initial begin
    repeat (2) stepCycle();
    checkOutput("rstValid", 32'(valid), 32'h0);
    checkOutput("rstInst", inst, 32'h0000_0013);
    checkOutput("rstReq", 32'(mem_req), 32'h0);
    checkOutput("rstAddr", mem_addr, 32'h0);

    // Cold start
    rst = 1'b1;
    checkOutput("coldValid", 32'(valid), 32'h0);
    serveFill(32'h8000_0000, 0);

    // Sequential hits
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0);
      stepCycle();
      checkOutput("seqValid", 32'(valid), 32'h1);
      checkOutput("seqInst", inst, memWord(32'h8000_0000 + 32'(4 * i)));
      checkOutput("seqReq", 32'(mem_req), 32'h0);
    end
    applyStimulus(1'b0, 32'h8000_000C, 1'b0);

    // Conflict eviction on index 0
    applyStimulus(1'b1, 32'h8000_0100, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'h8000_0100, 1'b0);
    checkOutput("conflictValid", 32'(valid), 32'h0);
    serveFill(32'h8000_0100, 0);

    // Revisit the evicted line with delayed acks
    applyStimulus(1'b1, 32'h8000_0000, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'h8000_0000, 1'b0);
    checkOutput("revisitValid", 32'(valid), 32'h0);
    serveFill(32'h8000_0000, 3);

    // Flush in IDLE while hitting
    applyStimulus(1'b0, 32'h8000_0000, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 32'h8000_0000, 1'b0);
    checkOutput("flushIdleValid", 32'(valid), 32'h0);
    serveFill(32'h8000_0000, 0);

    // Flush during FILL word 1
    applyStimulus(1'b1, 32'h8000_0100, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'h8000_0100, 1'b0);
    serveWord(32'h8000_0100, 0);
    checkOutput("flushFillAddr", mem_addr, 32'h8000_0104);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    serveWord(32'h8000_0104, 0);
    serveWord(32'h8000_0108, 0);
    serveWord(32'h8000_010C, 0);
    checkOutput("pendDoneValid", 32'(valid), 32'h0);
    stepCycle();
    checkOutput("pendFlushValid", 32'(valid), 32'h0);
    serveFill(32'h8000_0100, 0);

    // Reset mid-refill after two acks
    applyStimulus(1'b1, 32'h8000_0000, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'h8000_0000, 1'b0);
    serveWord(32'h8000_0000, 0);
    serveWord(32'h8000_0004, 0);
    checkOutput("preRstReq", 32'(mem_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midRstReq", 32'(mem_req), 32'h0);
    checkOutput("midRstValid", 32'(valid), 32'h0);
    checkOutput("midRstAddr", mem_addr, 32'h0);
    checkOutput("midRstInst", inst, 32'h0000_0013);
    applyStimulus(1'b0, 32'h8000_0200, 1'b0);
    stepCycle();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_DEAD;
    stepCycle();
    rst = 1'b1;
    checkOutput("postRstValid", 32'(valid), 32'h0);
    stepCycle();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    serveFill(32'h8000_0000, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
